// File: rtl/clock_step_controller.sv
// Single-step / slow / fast clock-enable generator for a CPU core, with a
// synchronized and debounced step button and a sticky halt latch.
module clock_step_controller #(
    parameter int unsigned SLOW_DIV  = 100000000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic        resume,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] step_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_STEP = 2'b01,
        S_SLOW = 2'b10,
        S_FAST = 2'b11
    } state_t;

    localparam logic [27:0] DIV_LAST = 28'(SLOW_DIV - 1);
    localparam logic [23:0] DB_LAST  = 24'(DB_CYCLES - 1);

    logic        sync_q1, sync_q2;
    logic        db_level, db_prev;
    logic [23:0] db_cnt;
    logic        step_evt;

    state_t      state_q, state_d;
    logic [27:0] div_q, div_d;
    logic        cpu_en_d, halted_d;

    // NOTE: sequential state is written only with <= so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= step_btn;
            sync_q2 <= sync_q1;
        end
    end

    // The level moves only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (sync_q2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_q2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 24'd1;
            end
        end
    end

    assign step_evt = db_level & ~db_prev;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HALT;
            div_q    <= '0;
            cpu_en   <= 1'b0;
            halted   <= 1'b0;
            step_cnt <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cpu_en   <= cpu_en_d;
            halted   <= halted_d;
            step_cnt <= step_cnt + {15'd0, cpu_en};
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through it can leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = halted ? S_HALT : state_t'(mode);
        div_d    = '0;
        cpu_en_d = 1'b0;
        halted_d = halted;

        if (state_q == S_SLOW && state_d == S_SLOW && div_q != DIV_LAST)
            div_d = div_q + 28'd1;

        unique case (state_q)
            S_HALT: cpu_en_d = 1'b0;
            S_STEP: cpu_en_d = step_evt;
            S_SLOW: cpu_en_d = (div_q == DIV_LAST);
            S_FAST: cpu_en_d = 1'b1;
        endcase

        // A halt request kills the enable on the same edge it is seen.
        if (halt_req || halted)
            cpu_en_d = 1'b0;

        if (halt_req)
            halted_d = 1'b1;
        else if (resume)
            halted_d = 1'b0;
    end

    assign state = state_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller with SLOW_DIV=4, DB_CYCLES=3.
// Inputs change and outputs are sampled on the falling edge of clk_in.
module tb_clock_step_controller;

    localparam int unsigned SLOW_DIV  = 4;
    localparam int unsigned DB_CYCLES = 3;

    logic        clk_in   = 1'b0;
    logic        rst_n    = 1'b1;
    logic [1:0]  mode     = 2'b00;
    logic        step_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume   = 1'b0;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] step_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    clock_step_controller #(
        .SLOW_DIV (SLOW_DIV),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .mode    (mode),
        .step_btn(step_btn),
        .halt_req(halt_req),
        .resume  (resume),
        .cpu_en  (cpu_en),
        .halted  (halted),
        .state   (state),
        .step_cnt(step_cnt)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        mode     = 2'b00;
        step_btn = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %0b want 0", cpu_en); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (step_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_step_cnt: got %0d want 0", step_cnt); end
        mode = 2'b11;
        tick(2);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_hold_state: got %0d want 0", state); end
        rst_n = 1'b1;
        tick(1);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL reset_first_load: got %0d want 3", state); end
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_first_cpu_en: got %0b want 0", cpu_en); end
    endtask

    task automatic test_fast();
        logic exp;
        do_reset();
        mode = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            exp = (k >= 2);
            n_checks++;
            if (cpu_en !== exp) begin n_fail++; $display("FAIL fast_cpu_en[%0d]: got %0b want %0b", k, cpu_en, exp); end
        end
        mode = 2'b00;
        tick(1);
        n_checks++; if (step_cnt !== 16'd9) begin n_fail++; $display("FAIL fast_step_cnt: got %0d want 9", step_cnt); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL fast_mode_change_state: got %0d want 0", state); end
        n_checks++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL fast_cpu_en_latency1: got %0b want 1", cpu_en); end
        tick(1);
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL fast_cpu_en_latency2: got %0b want 0", cpu_en); end
        n_checks++; if (step_cnt !== 16'd10) begin n_fail++; $display("FAIL fast_step_cnt_final: got %0d want 10", step_cnt); end
    endtask

    task automatic test_slow();
        logic exp;
        do_reset();
        mode = 2'b10;
        for (int k = 1; k <= 13; k++) begin
            tick(1);
            if (k == 1) begin
                n_checks++;
                if (state !== 2'd2) begin n_fail++; $display("FAIL slow_state: got %0d want 2", state); end
            end
            exp = (k == 5 || k == 9 || k == 13);
            n_checks++;
            if (cpu_en !== exp) begin n_fail++; $display("FAIL slow_cpu_en[%0d]: got %0b want %0b", k, cpu_en, exp); end
        end
        mode = 2'b00;
        tick(1);
        n_checks++; if (step_cnt !== 16'd3) begin n_fail++; $display("FAIL slow_step_cnt: got %0d want 3", step_cnt); end
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL slow_cpu_en_after: got %0b want 0", cpu_en); end
    endtask

    task automatic test_step();
        bit pat[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int pulses   = 0;
        int pulse_at = -1;
        int idx      = 0;
        int wide     = 0;
        logic prev   = 1'b0;
        do_reset();
        mode = 2'b01;
        tick(2);
        for (int i = 0; i < 25; i++) begin
            if (i < 9) step_btn = pat[i];
            else if (i < 15) step_btn = 1'b1;
            else step_btn = 1'b0;
            tick(1);
            idx++;
            if (cpu_en === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = idx;
                if (prev === 1'b1) wide++;
            end
            prev = cpu_en;
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL step_pulses: got %0d want 1", pulses); end
        n_checks++; if (pulse_at != 8) begin n_fail++; $display("FAIL step_pulse_time: got %0d want 8", pulse_at); end
        n_checks++; if (wide != 0) begin n_fail++; $display("FAIL step_pulse_width: got %0d wide cycles want 0", wide); end
        n_checks++; if (step_cnt !== 16'd1) begin n_fail++; $display("FAIL step_cnt: got %0d want 1", step_cnt); end

        mode   = 2'b00;
        pulses = 0;
        tick(2);
        for (int i = 0; i < 15; i++) begin
            step_btn = (i < 9) ? pat[i] : 1'b1;
            tick(1);
            if (cpu_en === 1'b1) pulses++;
        end
        mode = 2'b01;
        tick(6);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (cpu_en === 1'b1) pulses++;
        end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (cpu_en === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL step_discard_pulses: got %0d want 0", pulses); end
        n_checks++; if (step_cnt !== 16'd1) begin n_fail++; $display("FAIL step_discard_cnt: got %0d want 1", step_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        mode = 2'b11;
        tick(3);
        n_checks++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL halt_pre_cpu_en: got %0b want 1", cpu_en); end
        halt_req = 1'b1;
        tick(1);
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_cpu_en: got %0b want 0", cpu_en); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %0b want 1", halted); end
        halt_req = 1'b0;
        tick(1);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL halt_state: got %0d want 0", state); end
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_cpu_en_hold: got %0b want 0", cpu_en); end
        tick(2);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL halt_state_hold: got %0d want 0", state); end
        resume = 1'b1;
        tick(1);
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL resume_halted: got %0b want 0", halted); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL resume_state0: got %0d want 0", state); end
        resume = 1'b0;
        tick(1);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL resume_state: got %0d want 3", state); end
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL resume_cpu_en0: got %0b want 0", cpu_en); end
        tick(1);
        n_checks++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL resume_cpu_en1: got %0b want 1", cpu_en); end
    endtask

    task automatic test_back_to_back();
        halt_req = 1'b1;
        resume   = 1'b1;
        tick(1);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL both_set_halted: got %0b want 1", halted); end
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL both_cpu_en: got %0b want 0", cpu_en); end
        tick(1);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL both_hold_halted: got %0b want 1", halted); end
        halt_req = 1'b0;
        tick(1);
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL both_release_halted: got %0b want 0", halted); end
        resume = 1'b0;
    endtask

    task automatic test_wrap();
        int k = 0;
        do_reset();
        mode = 2'b11;
        while (step_cnt !== 16'hFFFF && k < 70000) begin
            tick(1);
            k++;
        end
        n_checks++; if (k != 65537) begin n_fail++; $display("FAIL wrap_preload_cycles: got %0d want 65537", k); end
        tick(1);
        n_checks++; if (step_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_step_cnt: got %0h want 0", step_cnt); end
        n_checks++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL wrap_cpu_en: got %0b want 1", cpu_en); end
    endtask

    task automatic test_reset_mid();
        logic exp;
        int pulses = 0;
        do_reset();
        mode = 2'b11;
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL mid_pre_halted: got %0b want 1", halted); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL mid_reset_halted: got %0b want 0", halted); end
        @(negedge clk_in);
        rst_n = 1'b1;

        mode = 2'b10;
        tick(7);
        n_checks++; if (step_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_pre_step_cnt: got %0d want 1", step_cnt); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL mid_pre_state: got %0d want 2", state); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d want 0", state); end
        n_checks++; if (step_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset_step_cnt: got %0d want 0", step_cnt); end
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_cpu_en: got %0b want 0", cpu_en); end
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            if (k == 1) begin
                n_checks++;
                if (state !== 2'd2) begin n_fail++; $display("FAIL mid_restart_state: got %0d want 2", state); end
            end
            exp = (k == 5);
            n_checks++;
            if (cpu_en !== exp) begin n_fail++; $display("FAIL mid_restart_cpu_en[%0d]: got %0b want %0b", k, cpu_en, exp); end
        end

        mode     = 2'b01;
        step_btn = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        step_btn = 1'b0;
        #1;
        @(negedge clk_in);
        rst_n = 1'b1;
        mode  = 2'b01;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (cpu_en === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL mid_debounce_pulses: got %0d want 0", pulses); end
        n_checks++; if (step_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_debounce_step_cnt: got %0d want 0", step_cnt); end
    endtask

    initial begin
        test_reset();
        test_fast();
        test_slow();
        test_step();
        test_halt();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
